palette_arbiter: RTL and testbench
==================================

# palette_arbiter

Shares one 16-entry, 12-bit RGB palette between up to NUM_REQ pixel sources (background, player tank, enemy tanks, projectiles). Each cycle it grants at most one pending 4-bit colour-index request, round-robin, and returns a registered RGB444 result tagged with the requester ID. It sits between the sprite and background fetch logic and the VGA colour mux, replacing per-sprite palette copies. It is also the single point where the palette can be reprogrammed at run time.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- ID_W, 2: width of the requester ID, equal to ceil(log2(NUM_REQ)).
- Clk  in  1: rising-edge clock.
- Reset_n  in  1: asynchronous, active-low reset.
- req  in  NUM_REQ: request bit per requester; held until acked.
- req_index  in  NUM_REQ*4: colour index per requester; requester i uses bits [4i+3:4i]; stable while req[i]=1.
- ack  out  NUM_REQ: combinational one-hot; ack[i]=1 marks the cycle in which request i is accepted.
- out_valid  out  1: out_red/green/blue/id hold a valid result.
- out_ready  in  1: downstream accepts the result.
- out_red, out_green, out_blue  out  4 each: looked-up colour.
- out_id  out  ID_W: requester that produced the result.
- wr_en  in  1: palette write strobe (PALETTE_WRITE_EN only).
- wr_addr  in  4: palette entry to write (PALETTE_WRITE_EN only).
- wr_rgb  in  12: {R,G,B} value to write (PALETTE_WRITE_EN only).

## Operation
- Palette contents at reset, entries 0..15: 9AA, 232, 777, DDE, 563, 8A7, DD9, 888, 443, 685, 665, 111, BCD, AB8, 8A3, 352.
- Round-robin pointer `ptr`, width ID_W, resets to 0.
- Grant search starts at requester `ptr` and wraps modulo NUM_REQ; the first requester with req=1 wins.
- A grant is permitted only when the output register can load: out_valid=0, or out_ready=1.
- On a grant to requester g:
  - ack[g]=1 in that cycle.
  - At the clock edge, the output register loads palette[req_index[g]] and g.
  - ptr becomes (g+1) mod NUM_REQ.
- With no grant, ptr holds.
- Output register:
  - Loads on a grant.
  - Clears out_valid when out_valid=1, out_ready=1 and there is no new grant.
  - Otherwise holds, including under stall.
- States are IDLE (out_valid=0) and FULL (out_valid=1).
  - IDLE goes to FULL on a grant.
  - FULL stays FULL on ready plus a grant, or on stall.
  - FULL goes to IDLE on ready with no request.
- At most one ack bit is set in any cycle. ack is 0 whenever a grant is not permitted.

## Timing
- Reset (asynchronous assert, synchronous release):
  - out_valid=0, out_red/green/blue=0, out_id=0, ptr=0.
  - Palette returns to its reset contents.
  - ack=0 while Reset_n=0.
- Lookup latency is one cycle from ack to out_valid.
- Sustained throughput is one result per cycle while out_ready=1.
- Back-to-back requests from the same requester are served on consecutive cycles only if no other requester is pending.
- Reset asserted mid-stall discards the held result; no ack is re-issued for it.

## Configuration
- Macro: PALETTE_WRITE_EN.
- Defined:
  - wr_en/wr_addr/wr_rgb ports exist and the palette is 16×12 registers.
  - A write updates the entry at the clock edge, regardless of stall.
  - A lookup granted in the same cycle as a write to the same entry returns the old value. The new value is visible to grants from the next cycle.
- Undefined:
  - The write ports are absent.
  - The palette is constant, synthesised as logic or ROM with the reset contents, and reset has no effect on it.

## Test plan
- Reset, then req=0001 with index0=3, out_ready=1 → ack=0001 in cycle 0; cycle 1: out_valid=1, RGB=D,D,E, id=0.
- All four req=1, indices 0,1,2,3, out_ready=1 → acks 0001, 0010, 0100, 1000 on consecutive cycles; outputs 9AA, 232, 777, DDE with ids 0..3.
- out_ready=0 after the first result, with req[2] held → ack stays 0 and the output holds for the stall length. On ready, the held result is consumed and req[2] is acked in the same cycle.
- Reset_n pulsed low during a stall with out_valid=1 → out_valid=0 immediately; after release, ptr=0 and requester 0 wins over a simultaneous requester 3.
- PALETTE_WRITE_EN: write entry 5 ← F00 in the same cycle as a grant for index 5 → result 8A7. The next grant for index 5 returns F00.
- Fairness: req[1] held permanently, req[3] toggling → req[3] is acked within 2 cycles of every assertion and never starved.

Source files
------------

// File: rtl/palette_arbiter.sv
// -----------------------------------------------------------------------------
// palette_arbiter
//
// Shares one 16-entry RGB444 palette between NUM_REQ pixel sources. Each cycle
// at most one pending colour-index request is granted (round-robin, starting
// at the requester after the last one served). The looked-up colour is
// returned one cycle later in a registered output stage tagged with the
// requester ID.
//
// Optional feature macro: PALETTE_WRITE_EN
//   defined   : wr_en/wr_addr/wr_rgb ports exist; palette is 16x12 registers
//               that return to their power-up colours on reset.
//   undefined : palette is a constant table (logic/ROM), unaffected by reset.
//
// Ports:
//   Clk        in   rising-edge clock
//   Reset_n    in   asynchronous active-low reset
//   req        in   [NUM_REQ]    request per requester, held until acked
//   req_index  in   [NUM_REQ*4]  colour index, requester i at [4i+3:4i]
//   ack        out  [NUM_REQ]    one-hot accept strobe (combinational)
//   out_valid  out  output stage holds a result
//   out_ready  in   downstream consumes the result
//   out_red/out_green/out_blue  out [4] looked-up colour
//   out_id     out  [ID_W]       requester that produced the result
//   wr_en/wr_addr/wr_rgb  in     palette write port (PALETTE_WRITE_EN only)
// -----------------------------------------------------------------------------
module palette_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*4-1:0] req_index,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           out_red,
  output logic [3:0]           out_green,
  output logic [3:0]           out_blue,
  output logic [ID_W-1:0]      out_id
`ifdef PALETTE_WRITE_EN
  ,
  input  logic                 wr_en,
  input  logic [3:0]           wr_addr,
  input  logic [11:0]          wr_rgb
`endif
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  // Power-up palette colours, {R,G,B}.
  function automatic logic [11:0] palette_reset_value(input logic [3:0] idx);
    case (idx)
      4'd0:    return 12'h9AA;
      4'd1:    return 12'h232;
      4'd2:    return 12'h777;
      4'd3:    return 12'hDDE;
      4'd4:    return 12'h563;
      4'd5:    return 12'h8A7;
      4'd6:    return 12'hDD9;
      4'd7:    return 12'h888;
      4'd8:    return 12'h443;
      4'd9:    return 12'h685;
      4'd10:   return 12'h665;
      4'd11:   return 12'h111;
      4'd12:   return 12'hBCD;
      4'd13:   return 12'hAB8;
      4'd14:   return 12'h8A3;
      4'd15:   return 12'h352;
      default: return 12'h000;
    endcase
  endfunction

  state_t            state_q;
  state_t            state_d;
  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   ptr_d;
  logic [11:0]       out_rgb_q;
  logic [11:0]       out_rgb_d;
  logic [ID_W-1:0]   out_id_q;
  logic [ID_W-1:0]   out_id_d;

  logic              grant_ok;
  logic              grant_vld;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W-1:0]   cand;
  logic [3:0]        sel_index;
  logic [11:0]       lookup_rgb;

`ifdef PALETTE_WRITE_EN
  logic [11:0]       pal_q [16];
  logic [11:0]       pal_d [16];

  // Palette write path: a write lands at the edge whether or not the output is stalled.
  always_comb begin
    for (int e = 0; e < 16; e++) begin
      pal_d[e] = pal_q[e];
    end
    if (wr_en) begin
      pal_d[wr_addr] = wr_rgb;
    end else begin
      pal_d[wr_addr] = pal_q[wr_addr];
    end
  end

  // Palette storage; reset restores the power-up colours.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int e = 0; e < 16; e++) begin
        pal_q[e] <= palette_reset_value(4'(e));
      end
    end else begin
      for (int e = 0; e < 16; e++) begin
        pal_q[e] <= pal_d[e];
      end
    end
  end
`endif

  // Round-robin search from ptr; ack is suppressed while the output cannot load or in reset.
  always_comb begin
    grant_ok  = Reset_n && ((state_q == ST_IDLE) || out_ready);
    grant_vld = 1'b0;
    grant_id  = {ID_W{1'b0}};
    cand      = {ID_W{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!grant_vld && req[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end else begin
        grant_vld = grant_vld;
      end
    end
    if (!grant_ok) begin
      grant_vld = 1'b0;
    end else begin
      grant_vld = grant_vld;
    end
  end

  // Ack decode, palette lookup of the winner's index, and pointer advance.
  always_comb begin
    sel_index = req_index[{grant_id, 2'b00} +: 4];
`ifdef PALETTE_WRITE_EN
    // Reads the registered palette, so a same-cycle write is not yet visible.
    lookup_rgb = pal_q[sel_index];
`else
    lookup_rgb = palette_reset_value(sel_index);
`endif
    if (grant_vld) begin
      ack = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
      if (grant_id == ID_W'(NUM_REQ - 1)) begin
        ptr_d = {ID_W{1'b0}};
      end else begin
        ptr_d = grant_id + {{(ID_W-1){1'b0}}, 1'b1};
      end
      out_rgb_d = lookup_rgb;
      out_id_d  = grant_id;
    end else begin
      ack       = {NUM_REQ{1'b0}};
      ptr_d     = ptr_q;
      out_rgb_d = out_rgb_q;
      out_id_d  = out_id_q;
    end
  end

  // Output-stage FSM next state: a grant always fills; ready without a grant drains.
  always_comb begin
    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          state_d = ST_FULL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FULL: begin
        if (grant_vld) begin
          state_d = ST_FULL;
        end else if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output-stage FSM outputs, decoded from the state register only.
  always_comb begin
    case (state_q)
      ST_FULL: out_valid = 1'b1;
      ST_IDLE: out_valid = 1'b0;
      default: out_valid = 1'b0;
    endcase
  end

  // State, pointer and result registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= {ID_W{1'b0}};
      out_rgb_q <= 12'h000;
      out_id_q  <= {ID_W{1'b0}};
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      out_rgb_q <= out_rgb_d;
      out_id_q  <= out_id_d;
    end
  end

  assign out_red   = out_rgb_q[11:8];
  assign out_green = out_rgb_q[7:4];
  assign out_blue  = out_rgb_q[3:0];
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_palette_arbiter.sv
module tb_palette_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic           Clk;
  logic           Reset_n;
  logic [N-1:0]   req;
  logic [N*4-1:0] req_index;
  logic [N-1:0]   ack;
  logic           out_valid;
  logic           out_ready;
  logic [3:0]     out_red;
  logic [3:0]     out_green;
  logic [3:0]     out_blue;
  logic [IW-1:0]  out_id;
`ifdef PALETTE_WRITE_EN
  logic           wr_en;
  logic [3:0]     wr_addr;
  logic [11:0]    wr_rgb;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic run = 1'b0;

  palette_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .req(req), .req_index(req_index), .ack(ack),
    .out_valid(out_valid), .out_ready(out_ready), .out_red(out_red),
    .out_green(out_green), .out_blue(out_blue), .out_id(out_id)
`ifdef PALETTE_WRITE_EN
    , .wr_en(wr_en), .wr_addr(wr_addr), .wr_rgb(wr_rgb)
`endif
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  localparam logic [11:0] PAL_INIT [16] = '{
    12'h9AA, 12'h232, 12'h777, 12'hDDE, 12'h563, 12'h8A7, 12'hDD9, 12'h888,
    12'h443, 12'h685, 12'h665, 12'h111, 12'hBCD, 12'hAB8, 12'h8A3, 12'h352};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [11:0] m_pal [16];
  logic        m_valid;
  logic [11:0] m_rgb;
  int          m_id;
  int          m_ptr;
  int          m_g;
  logic [N-1:0] m_ack;

  // Winner = pending requester at the smallest circular distance from ptr.
  function automatic int model_grant(input logic rn, input logic rdy, input logic [N-1:0] r,
                                     input logic v, input int p);
    int best;
    int bestd;
    best  = -1;
    bestd = N;
    if (rn !== 1'b1) return -1;
    if (v && !rdy) return -1;
    for (int i = 0; i < N; i++) begin
      if (r[i] && (((i - p + N) % N) < bestd)) begin
        bestd = (i - p + N) % N;
        best  = i;
      end
    end
    return best;
  endfunction

  always_comb begin
    m_g = model_grant(Reset_n, out_ready, req, m_valid, m_ptr);
    if (m_g >= 0) m_ack = N'(1 << m_g);
    else          m_ack = '0;
  end

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_valid <= 1'b0;
      m_rgb   <= 12'h000;
      m_id    <= 0;
      m_ptr   <= 0;
      for (int e = 0; e < 16; e++) m_pal[e] <= PAL_INIT[e];
    end else begin
      if (m_g >= 0) begin
        m_valid <= 1'b1;
        m_rgb   <= m_pal[req_index[4*m_g +: 4]];
        m_id    <= m_g;
        m_ptr   <= (m_g + 1) % N;
      end else if (out_ready) begin
        m_valid <= 1'b0;
      end
`ifdef PALETTE_WRITE_EN
      if (wr_en) m_pal[wr_addr] <= wr_rgb;
`endif
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge Clk) begin
    if (run) begin
      check("cmp_ack", 32'(ack), 32'(m_ack));
      check("cmp_valid", 32'(out_valid), 32'(m_valid));
      check("cmp_rgb", 32'({out_red, out_green, out_blue}), 32'(m_rgb));
      check("cmp_id", 32'(out_id), 32'(m_id));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic [N-1:0] r, input logic rdy);
    req = r;
    out_ready = rdy;
    #3;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_reset();
    Reset_n = 1'b0;
    req = 4'b1111;
    #2;
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_rgb", 32'({out_red, out_green, out_blue}), 32'h0);
    check("rst_id", 32'(out_id), 32'h0);
    Reset_n = 1'b1;
    req = 4'b0000;
  endtask

  logic [N-1:0] b_req [5]  = '{4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
  logic [N-1:0] b_ack [5]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
  logic [11:0]  b_rgb [4]  = '{12'h9AA, 12'h232, 12'h777, 12'hDDE};

  initial begin
    logic r3;
    logic nr3;
    int   w3;
    int   n_ack3;
    Reset_n = 1'b1;
    req = '0;
    req_index = '0;
    out_ready = 1'b1;
`ifdef PALETTE_WRITE_EN
    wr_en = 1'b0;
    wr_addr = 4'd0;
    wr_rgb = 12'h000;
`endif
    #2;
    Reset_n = 1'b0;
    req = 4'b1111;
    run = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    check("reset_ack", 32'(ack), 32'h0);
    check("reset_valid", 32'(out_valid), 32'h0);
    check("reset_rgb", 32'({out_red, out_green, out_blue}), 32'h0);
    Reset_n = 1'b1;
    req = '0;
    tick();

    // A: single request, index 3 -> DDE one cycle later
    req_index = 16'h0003;
    drive(4'b0001, 1'b1);
    check("A_ack", 32'(ack), 32'h1);
    tick();
    drive(4'b0000, 1'b1);
    check("A_valid", 32'(out_valid), 32'h1);
    check("A_rgb", 32'({out_red, out_green, out_blue}), 32'hDDE);
    check("A_id", 32'(out_id), 32'h0);
    tick();

    // B: all four requesters, served in order 0..3
    pulse_reset();
    tick();
    req_index = 16'h3210;
    for (int c = 0; c < 5; c++) begin
      drive(b_req[c], 1'b1);
      check("B_ack", 32'(ack), 32'(b_ack[c]));
      if (c > 0) begin
        check("B_rgb", 32'({out_red, out_green, out_blue}), 32'(b_rgb[c-1]));
        check("B_id", 32'(out_id), 32'(c - 1));
      end
      tick();
    end

    // C: stall holds the result, req[2] acked as it drains
    drive(4'b0001, 1'b1);
    check("C_ack0", 32'(ack), 32'h1);
    tick();
    for (int s = 0; s < 3; s++) begin
      drive(4'b0100, 1'b0);
      check("C_stall_ack", 32'(ack), 32'h0);
      check("C_stall_rgb", 32'({out_red, out_green, out_blue}), 32'h9AA);
      tick();
    end
    drive(4'b0100, 1'b1);
    check("C_drain_ack", 32'(ack), 32'h4);
    tick();
    drive(4'b0000, 1'b1);
    check("C_rgb", 32'({out_red, out_green, out_blue}), 32'h777);
    check("C_id", 32'(out_id), 32'h2);
    tick();

    // D: reset during a stall drops the held result; ptr back to 0
    drive(4'b0010, 1'b1);
    check("D_ack", 32'(ack), 32'h2);
    tick();
    drive(4'b0000, 1'b0);
    check("D_hold", 32'(out_valid), 32'h1);
    Reset_n = 1'b0;
    req = 4'b1001;
    #1;
    check("D_rst_valid", 32'(out_valid), 32'h0);
    tick();
    check("D_rst_ack", 32'(ack), 32'h0);
    Reset_n = 1'b1;
    drive(4'b1001, 1'b1);
    check("D_ptr0_ack", 32'(ack), 32'h1);
    tick();
    drive(4'b1000, 1'b1);
    check("D_ack3", 32'(ack), 32'h8);
    tick();
    drive(4'b0000, 1'b1);
    tick();

    // E: fairness, req[1] always on, req[3] toggles after each ack
    r3 = 1'b1;
    w3 = 0;
    n_ack3 = 0;
    for (int c = 0; c < 24; c++) begin
      drive({r3, 1'b0, 1'b1, 1'b0}, 1'b1);
      nr3 = 1'b1;
      if (r3) begin
        if (ack[3]) begin
          n_ack3++;
          nr3 = 1'b0;
          w3 = 0;
        end else begin
          w3++;
          check("E_wait", 32'(w3 <= 1), 32'h1);
        end
      end
      tick();
      r3 = nr3;
    end
    check("E_acks3", 32'(n_ack3), 32'd12);
    drive(4'b0000, 1'b1);
    tick();

`ifdef PALETTE_WRITE_EN
    // F: same-cycle write returns old colour, later grant sees the new one
    drive(4'b0000, 1'b1);
    tick();
    req_index = 16'h0005;
    wr_en = 1'b1;
    wr_addr = 4'd5;
    wr_rgb = 12'hF00;
    drive(4'b0001, 1'b1);
    check("F_ack", 32'(ack), 32'h1);
    tick();
    wr_en = 1'b0;
    drive(4'b0000, 1'b1);
    check("F_old", 32'({out_red, out_green, out_blue}), 32'h8A7);
    tick();
    drive(4'b0001, 1'b1);
    tick();
    drive(4'b0000, 1'b1);
    check("F_new", 32'({out_red, out_green, out_blue}), 32'hF00);
    tick();
    pulse_reset();
    tick();
    drive(4'b0001, 1'b1);
    tick();
    drive(4'b0000, 1'b1);
    check("F_reset_pal", 32'({out_red, out_green, out_blue}), 32'h8A7);
    tick();
`endif

    run = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
